// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase tracker: default phase width,
// tracker FSM states and accumulator width derivation.
package dds_pkg;

    localparam int unsigned PHASE_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PRIMED,
        S_MEASURE
    } tracker_state_t;

    // Accumulator must hold 2^gate_log2 full-scale deltas without overflow.
    function automatic int unsigned sum_width(input int unsigned phase_width,
                                              input int unsigned gate_log2);
        return phase_width + gate_log2;
    endfunction

endpackage

// File: rtl/phase_delta_calc.sv
// Combinational step analysis: modular phase delta, tolerance check against the
// previous delta, and wrap detection.
module phase_delta_calc
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned TOLERANCE   = 0
) (
    input  logic [PHASE_WIDTH-1:0] phase_i,
    input  logic [PHASE_WIDTH-1:0] prev_i,
    input  logic [PHASE_WIDTH-1:0] ref_delta_i,
    output logic [PHASE_WIDTH-1:0] delta_o,
    output logic                   in_tol_o,
    output logic                   wrapped_o
);

    logic [PHASE_WIDTH-1:0] diff;

    always_comb begin
        delta_o   = phase_i - prev_i;
        diff      = (delta_o >= ref_delta_i) ? (delta_o - ref_delta_i)
                                             : (ref_delta_i - delta_o);
        in_tol_o  = (32'(diff) <= TOLERANCE);
        wrapped_o = (phase_i < prev_i);
    end

endmodule

// File: rtl/phase_tracker.sv
// Recovers the DDS tuning increment from a stream of wrapped phase words.
// Optional wrap_count output is enabled by defining WRAP_COUNT_EN.
module phase_tracker
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int unsigned GATE_LOG2   = 4,
    parameter int unsigned LOCK_COUNT  = 8,
    parameter int unsigned TOLERANCE   = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PHASE_WIDTH-1:0] phase_in,
    input  logic                   phase_valid,
    input  logic                   clear,
    output logic [PHASE_WIDTH-1:0] inc_est,
    output logic                   inc_valid,
    output logic                   locked,
`ifdef WRAP_COUNT_EN
    output logic [15:0]            wrap_count,
`endif
    output logic                   glitch
);

    localparam int unsigned SUM_WIDTH = sum_width(PHASE_WIDTH, GATE_LOG2);
    localparam int unsigned STABLE_W  = $clog2(LOCK_COUNT + 1);
    localparam logic [GATE_LOG2:0]  GATE_LEN = (GATE_LOG2 + 1)'(1 << GATE_LOG2);
    localparam logic [STABLE_W-1:0] LOCK_MAX = STABLE_W'(LOCK_COUNT);

    tracker_state_t         state_q, state_d;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d, sum_next;
    logic [GATE_LOG2:0]     cnt_q, cnt_d, cnt_inc;
    logic [STABLE_W-1:0]    stable_q, stable_d;
    logic [PHASE_WIDTH-1:0] prev_q, prev_d;
    logic [PHASE_WIDTH-1:0] ref_q, ref_d;
    logic [PHASE_WIDTH-1:0] inc_est_q, inc_est_d;
    logic                   inc_valid_q, inc_valid_d;
    logic                   locked_q, locked_d;
    logic                   glitch_q, glitch_d;
    logic [PHASE_WIDTH-1:0] delta;
    logic                   in_tol;
    logic                   wrapped;

    phase_delta_calc #(
        .PHASE_WIDTH(PHASE_WIDTH),
        .TOLERANCE  (TOLERANCE)
    ) u_delta (
        .phase_i    (phase_in),
        .prev_i     (prev_q),
        .ref_delta_i(ref_q),
        .delta_o    (delta),
        .in_tol_o   (in_tol),
        .wrapped_o  (wrapped)
    );

`ifdef WRAP_COUNT_EN
    logic [15:0] wrap_q, wrap_d;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        wrap_d = wrap_q;
        if (phase_valid && (state_q != S_EMPTY) && wrapped && (wrap_q != 16'hFFFF)) begin
            wrap_d = wrap_q + 16'd1;
        end
    end

    assign wrap_count = wrap_q;
`else
    logic unused_wrapped;
    assign unused_wrapped = wrapped;
`endif

    // Clear behaves exactly like reset and also drops any coincident sample.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q     <= S_EMPTY;
            sum_q       <= '0;
            cnt_q       <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            ref_q       <= '0;
            inc_est_q   <= '0;
            inc_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            glitch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            prev_q      <= prev_d;
            ref_q       <= ref_d;
            inc_est_q   <= inc_est_d;
            inc_valid_q <= inc_valid_d;
            locked_q    <= locked_d;
            glitch_q    <= glitch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (phase_valid) begin
            unique case (state_q)
                S_EMPTY:   state_d = S_PRIMED;
                S_PRIMED:  state_d = S_MEASURE;
                S_MEASURE: state_d = S_MEASURE;
                default:   state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        stable_d    = stable_q;
        prev_d      = prev_q;
        ref_d       = ref_q;
        inc_est_d   = inc_est_q;
        inc_valid_d = 1'b0;
        locked_d    = locked_q;
        glitch_d    = 1'b0;
        sum_next    = sum_q + SUM_WIDTH'(delta);
        cnt_inc     = cnt_q + 1'b1;

        if (phase_valid) begin
            prev_d = phase_in;
            unique case (state_q)
                S_PRIMED: begin
                    ref_d    = delta;
                    sum_d    = SUM_WIDTH'(delta);
                    cnt_d    = (GATE_LOG2 + 1)'(1);
                    stable_d = STABLE_W'(1);
                end
                S_MEASURE: begin
                    sum_d = sum_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == GATE_LEN) begin
                        inc_est_d   = sum_next[SUM_WIDTH-1:GATE_LOG2];
                        inc_valid_d = 1'b1;
                        sum_d       = '0;
                        cnt_d       = '0;
                    end
                    if (in_tol) begin
                        if (stable_q < LOCK_MAX) begin
                            stable_d = stable_q + 1'b1;
                        end
                        if (stable_d == LOCK_MAX) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        stable_d = STABLE_W'(1);
                        locked_d = 1'b0;
                        glitch_d = 1'b1;
                    end
                    ref_d = delta;
                end
                default: ;
            endcase
        end
    end

    assign inc_est   = inc_est_q;
    assign inc_valid = inc_valid_q;
    assign locked    = locked_q;
    assign glitch    = glitch_q;

endmodule
